// File: rtl/instruction_fetch_unit_if.sv
// Instruction fetch unit bus: program-load port, controller strobes and
// the decoded instruction fields returned to the controller.
interface instruction_fetch_unit_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 8
);
    // Mode request and program-memory write port
    logic                   run;
    logic                   prog_we;
    logic [ADDR_WIDTH-1:0]  prog_addr;
    logic [INSTR_WIDTH-1:0] prog_data;

    // Controller strobes
    logic                   LoadIR;
    logic                   IncPC;
    logic                   LoadPC;
    logic [ADDR_WIDTH-1:0]  pc_jump;
    logic                   resetPC;

    // Fetch results
    logic [ADDR_WIDTH-1:0]  currentPC;
    logic [3:0]             Opcode;
    logic [3:0]             immediate;
    logic [3:0]             regAddress;
    logic                   fetch_valid;
    logic                   running;

    // Controller / loader side
    modport master (
        output run, prog_we, prog_addr, prog_data,
        output LoadIR, IncPC, LoadPC, pc_jump, resetPC,
        input  currentPC, Opcode, immediate, regAddress, fetch_valid, running
    );

    // Fetch unit side
    modport slave (
        input  run, prog_we, prog_addr, prog_data,
        input  LoadIR, IncPC, LoadPC, pc_jump, resetPC,
        output currentPC, Opcode, immediate, regAddress, fetch_valid, running
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: program memory, program counter, instruction
// register and a two-state LOAD/RUN mode machine. In LOAD the memory is
// written from the program port; in RUN the controller strobes walk the PC
// and capture instructions into IR. Memory has no reset so a loaded program
// survives Reset.
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 8
) (
    input logic                      Clk,
    input logic                      Reset,
    instruction_fetch_unit_if.slave  bus
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [ADDR_WIDTH-1:0]  pc_d;
    logic [INSTR_WIDTH-1:0] ir_q;
    logic [INSTR_WIDTH-1:0] ir_d;
    logic                   fv_q;
    logic                   fv_d;

    logic [INSTR_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [INSTR_WIDTH-1:0] mem_rdata;
    logic                   mem_we;

    // Writes are only accepted in LOAD; the read port always follows the PC.
    assign mem_we    = (state_q == LOAD) && bus.prog_we;
    assign mem_rdata = mem[pc_q];

    // Program memory write port (deliberately not reset)
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    // Mode state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode transitions follow the run level sampled at each edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (bus.run)  state_d = RUN;
            RUN:     if (!bus.run) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Next PC/IR/valid: entering RUN starts clean, leaving RUN drops valid,
    // and within RUN resetPC beats LoadPC beats IncPC. IR always captures the
    // word at the pre-edge PC, so a fetch and a PC step can share a cycle.
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        fv_d = fv_q;
        if (state_q == LOAD) begin
            if (bus.run) begin
                pc_d = '0;
                ir_d = '0;
                fv_d = 1'b0;
            end
        end else if (!bus.run) begin
            fv_d = 1'b0;
        end else if (bus.resetPC) begin
            pc_d = '0;
            ir_d = '0;
            fv_d = 1'b0;
        end else begin
            if (bus.LoadIR) begin
                ir_d = mem_rdata;
                fv_d = 1'b1;
            end
            if (bus.LoadPC) begin
                pc_d = bus.pc_jump;
            end else if (bus.IncPC) begin
                pc_d = pc_q + ADDR_WIDTH'(1);
            end
        end
    end

    // PC, IR and fetch-valid registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q <= '0;
            ir_q <= '0;
            fv_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
            fv_q <= fv_d;
        end
    end

    // Decoded fields come straight from IR, never from the memory read path
    assign bus.currentPC   = pc_q;
    assign bus.Opcode      = ir_q[7:4];
    assign bus.immediate   = ir_q[3:0];
    assign bus.regAddress  = ir_q[3:0];
    assign bus.fetch_valid = fv_q;
    assign bus.running     = (state_q == RUN);

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, program-counter and instruction-memory address width.
REQ-002 The block SHALL have parameter INSTR_WIDTH, default 8, instruction word width; [7:4] opcode, [3:0] operand.
REQ-003 The block SHALL have port Clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port run  input  1  level; 1 requests RUN mode, 0 requests LOAD mode.
REQ-006 The block SHALL have port prog_we  input  1  program-memory write strobe, honoured in LOAD only.
REQ-007 The block SHALL have port prog_addr  input  ADDR_WIDTH  program-memory write address.
REQ-008 The block SHALL have port prog_data  input  INSTR_WIDTH  program-memory write data.
REQ-009 The block SHALL have port LoadIR  input  1  capture mem[currentPC] into IR.
REQ-010 The block SHALL have port IncPC  input  1  increment PC.
REQ-011 The block SHALL have port LoadPC  input  1  load PC from pc_jump.
REQ-012 The block SHALL have port pc_jump  input  ADDR_WIDTH  jump target from the PC select mux.
REQ-013 The block SHALL have port resetPC  input  1  synchronous PC/IR clear.
REQ-014 The block SHALL have port currentPC  output  ADDR_WIDTH  registered PC.
REQ-015 The block SHALL have port Opcode  output  4  IR[7:4], to controller.
REQ-016 The block SHALL have port immediate  output  4  IR[3:0].
REQ-017 The block SHALL have port regAddress  output  4  IR[3:0], same bits as immediate.
REQ-018 The block SHALL have port fetch_valid  output  1  IR holds an instruction fetched in RUN.
REQ-019 The block SHALL have port running  output  1  1 while the FSM is in RUN.

Function
REQ-020 Memory SHALL be 2**ADDR_WIDTH x INSTR_WIDTH, written synchronously, read combinationally at currentPC.
REQ-021 FSM states SHALL be LOAD and RUN; LOAD->RUN on the edge where run=1, RUN->LOAD on the edge where run=0.
REQ-022 On a LOAD->RUN transition edge, PC SHALL be cleared to 0, IR to 0, and fetch_valid to 0.
REQ-023 In LOAD, prog_we=1 SHALL write prog_data to mem[prog_addr]; LoadIR/IncPC/LoadPC SHALL be ignored and PC/IR held.
REQ-024 In RUN, prog_we SHALL be ignored; memory contents SHALL be unchanged.
REQ-025 In RUN, PC update priority SHALL be resetPC > LoadPC > IncPC > hold.
REQ-026 IncPC SHALL produce PC+1 modulo 2**ADDR_WIDTH; 0xFF wraps to 0x00, no flag.
REQ-027 LoadPC SHALL load pc_jump exactly; the caller zero-extends 4-bit immediates upstream.
REQ-028 In RUN, LoadIR SHALL capture mem[PC value before the edge]; with simultaneous IncPC or LoadPC, IR gets the old-PC word and PC advances in the same cycle.
REQ-029 resetPC in RUN SHALL clear PC and IR to 0 and fetch_valid to 0, overriding LoadIR in the same cycle.
REQ-030 fetch_valid SHALL set on the edge after which LoadIR captured in RUN, and stay set until resetPC, a RUN->LOAD transition, or Reset.
REQ-031 Opcode/immediate/regAddress SHALL be pure slices of the IR register, with no combinational path from memory.

Reset
REQ-032 Reset=1 SHALL immediately force PC=0, IR=0, fetch_valid=0, state=LOAD, running=0, regardless of Clk.
REQ-033 Reset SHALL NOT clear memory contents; a loaded program survives Reset.
REQ-034 Reset asserted mid-RUN SHALL abort the fetch, and after deassertion the block SHALL stay in LOAD until a clock edge with run=1.

Verification
REQ-035 Load mem[0..3]=0x1A,0x2B,0x3C,0x4D, run=1, LoadIR+IncPC each cycle -> Opcode/immediate sequence 1/A,2/B,3/C,4/D, PC 1,2,3,4, fetch_valid=1 after first capture.
REQ-036 Run with PC=0xFF, IncPC -> PC=0x00 next edge; LoadPC=1 with pc_jump=0x40 and IncPC=1 -> PC=0x40.
REQ-037 PC=0x05, LoadIR+LoadPC with pc_jump=0x10 -> IR=mem[0x05], PC=0x10; next LoadIR -> IR=mem[0x10].
REQ-038 resetPC=1 with LoadIR=1 at PC=0x22 -> PC=0, IR=0x00, fetch_valid=0.
REQ-039 prog_we=1 to addr 0x00 with data 0xFF in RUN -> mem[0] unchanged, verified by fetch after resetPC.
REQ-040 Reset pulsed mid-RUN between clock edges -> outputs zero immediately, running=0; memory still returns the prior program after re-entering RUN.
